// File: rtl/lm_sm_sequencer.sv
// LM/SM expander between the fetch pipe register and decode.
// Multi-register loads/stores leave as one LW/SW micro-op per listed register; everything else passes through one register stage.
module lm_sm_sequencer #(
    parameter logic [3:0] OPC_LM = 4'b0110,
    parameter logic [3:0] OPC_SM = 4'b0111,
    parameter logic [3:0] OPC_LW = 4'b0100,
    parameter logic [3:0] OPC_SW = 4'b0101
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [15:0] in_PC,
    input  logic [15:0] in_IR,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_PC,
    output logic [15:0] out_IR,
    output logic        out_last,
    input  logic        out_ready
);

    typedef enum logic {IDLE, SEQ} state_t;

    state_t      state, state_nx;
    logic [7:0]  mask, mask_nx;
    logic [2:0]  base, base_nx;
    logic [2:0]  count, count_nx;
    logic        ra_hold, ra_hold_nx;
    logic [2:0]  ra_off, ra_off_nx;
    logic        is_sm, is_sm_nx;
    logic [15:0] seq_pc, seq_pc_nx;
    logic        out_valid_nx, out_last_nx;
    logic [15:0] out_PC_nx, out_IR_nx;

    logic        adv, accept, in_lm, in_sm;
    logic [2:0]  in_base, in_ra_off, pick, idx, off;
    logic [7:0]  rest;
    logic        last_op;

    assign adv      = !out_valid || out_ready;
    assign in_ready = (state == IDLE) && adv && !flush && !reset;
    assign accept   = in_ready && in_valid;
    assign in_lm    = (in_IR[15:12] == OPC_LM);
    assign in_sm    = (in_IR[15:12] == OPC_SM);
    assign in_base  = in_IR[11:9];

    // Memory slot of the deferred base register is its rank in the original list.
    always_comb begin
        in_ra_off = '0;
        for (int k = 0; k < 8; k++) begin
            if ((3'(k) < in_base) && in_IR[k]) in_ra_off = in_ra_off + 3'd1;
        end
        pick = '0;
        for (int k = 7; k >= 0; k--) begin
            if (mask[k]) pick = 3'(k);
        end
    end

    always_comb begin
        state_nx     = state;
        mask_nx      = mask;
        base_nx      = base;
        count_nx     = count;
        ra_hold_nx   = ra_hold;
        ra_off_nx    = ra_off;
        is_sm_nx     = is_sm;
        seq_pc_nx    = seq_pc;
        out_valid_nx = out_valid;
        out_last_nx  = out_last;
        out_PC_nx    = out_PC;
        out_IR_nx    = out_IR;
        rest         = mask;
        idx          = base;
        off          = ra_off;
        last_op      = 1'b0;

        if (flush) begin
            state_nx     = IDLE;
            mask_nx      = '0;
            ra_hold_nx   = 1'b0;
            out_valid_nx = 1'b0;
            out_last_nx  = 1'b0;
        end else if (adv) begin
            if (state == IDLE) begin
                if (accept && (in_lm || in_sm)) begin
                    mask_nx      = in_IR[7:0];
                    base_nx      = in_base;
                    is_sm_nx     = in_sm;
                    seq_pc_nx    = in_PC;
                    count_nx     = '0;
                    ra_off_nx    = in_ra_off;
                    ra_hold_nx   = 1'b0;
                    out_valid_nx = 1'b0;
                    out_last_nx  = 1'b0;
                    // An LM that reloads its own base register must do that load last.
                    if (in_lm && in_IR[in_base]) begin
                        mask_nx[in_base] = 1'b0;
                        ra_hold_nx       = 1'b1;
                    end
                    if (in_IR[7:0] != 8'h00) state_nx = SEQ;
                end else if (accept) begin
                    out_valid_nx = 1'b1;
                    out_last_nx  = 1'b1;
                    out_PC_nx    = in_PC;
                    out_IR_nx    = in_IR;
                end else begin
                    out_valid_nx = 1'b0;
                    out_last_nx  = 1'b0;
                end
            end else begin
                // Ops issue in ascending order, so earlier issues plus a skipped base give the rank.
                if (mask != 8'h00) begin
                    idx     = pick;
                    rest    = mask & ~(8'h01 << pick);
                    off     = count + {2'b00, (ra_hold && (base < pick))};
                    last_op = (rest == 8'h00) && !ra_hold;
                end else begin
                    ra_hold_nx = 1'b0;
                    last_op    = 1'b1;
                end
                mask_nx      = rest;
                count_nx     = count + 3'd1;
                out_valid_nx = 1'b1;
                out_last_nx  = last_op;
                out_PC_nx    = seq_pc;
                out_IR_nx    = {(is_sm ? OPC_SW : OPC_LW), idx, base, 3'b000, off};
                if (last_op) state_nx = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mask      <= '0;
            base      <= '0;
            count     <= '0;
            ra_hold   <= 1'b0;
            ra_off    <= '0;
            is_sm     <= 1'b0;
            seq_pc    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_PC    <= '0;
            out_IR    <= '0;
        end else begin
            state     <= state_nx;
            mask      <= mask_nx;
            base      <= base_nx;
            count     <= count_nx;
            ra_hold   <= ra_hold_nx;
            ra_off    <= ra_off_nx;
            is_sm     <= is_sm_nx;
            seq_pc    <= seq_pc_nx;
            out_valid <= out_valid_nx;
            out_last  <= out_last_nx;
            out_PC    <= out_PC_nx;
            out_IR    <= out_IR_nx;
        end
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Bench for lm_sm_sequencer: directed scenarios with known micro-op words, then random traffic
// checked cycle by cycle against a queue-based transaction model of the expansion.
module tb_lm_sm_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_PC = '0;
    logic [15:0] in_IR = '0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, out_last;
    logic [15:0] out_PC, out_IR;

    always #5 clk = ~clk;

    lm_sm_sequencer dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_PC(in_PC), .in_IR(in_IR), .in_ready(in_ready), .out_valid(out_valid),
        .out_PC(out_PC), .out_IR(out_IR), .out_last(out_last), .out_ready(out_ready)
    );

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ir;
        logic        last;
    } op_t;

    int  checks = 0;
    int  errors = 0;
    op_t pend[$];
    op_t exp_ops[$];
    op_t got[$];
    op_t head;
    bit  head_v = 1'b0;
    bit  exp_in_ready, exp_out_valid;
    op_t exp_head;

    // Expansion written from the instruction semantics: register list ascending, LM base deferred, slot = rank.
    function automatic void expand(input logic [15:0] pc, input logic [15:0] ir);
        logic [3:0] opc;
        logic [2:0] ra;
        int         regs[$];
        int         rank;
        op_t        o;
        exp_ops.delete();
        opc = ir[15:12];
        ra  = ir[11:9];
        if (opc != 4'b0110 && opc != 4'b0111) begin
            o.pc = pc; o.ir = ir; o.last = 1'b1;
            exp_ops.push_back(o);
            return;
        end
        for (int r = 0; r < 8; r++)
            if (ir[r] && !(opc == 4'b0110 && r == int'(ra))) regs.push_back(r);
        if (opc == 4'b0110 && ir[ra]) regs.push_back(int'(ra));
        foreach (regs[n]) begin
            rank = 0;
            for (int b = 0; b < regs[n]; b++) if (ir[b]) rank++;
            o.pc   = pc;
            o.ir   = {(opc == 4'b0110) ? 4'h4 : 4'h5, 3'(regs[n]), ra, 3'b000, 3'(rank)};
            o.last = (n == regs.size() - 1);
            exp_ops.push_back(o);
        end
    endfunction

    task automatic tick(input bit v, input logic [15:0] pc, input logic [15:0] ir,
                        input bit ordy, input bit fl);
        bit adv, acc;
        @(negedge clk);
        in_valid = v; in_PC = pc; in_IR = ir; out_ready = ordy; flush = fl;
        #1;
        adv           = !head_v || ordy;
        exp_in_ready  = !fl && !reset && (pend.size() == 0) && adv;
        exp_out_valid = head_v;
        exp_head      = head;
        acc           = v && exp_in_ready;
        if (fl || reset) begin
            head_v = 1'b0;
            pend.delete();
        end else if (adv) begin
            if (acc) begin
                expand(pc, ir);
                if (ir[15:13] == 3'b011) begin
                    pend   = exp_ops;
                    head_v = 1'b0;
                end else begin
                    head   = exp_ops[0];
                    head_v = 1'b1;
                end
            end else if (pend.size() > 0) begin
                head   = pend.pop_front();
                head_v = 1'b1;
            end else begin
                head_v = 1'b0;
            end
        end
    endtask

    task automatic issue(input logic [15:0] pc, input logic [15:0] ir, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, pc, ir, 1'b1, 1'b0);
            if (exp_in_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic collect(input int budget, output bit timed_out);
        got.delete();
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
            if (out_valid === 1'b1) begin
                got.push_back(op_t'({out_PC, out_IR, out_last}));
                if (out_last) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        tick(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        checks++;
        if ({out_valid, out_PC, out_IR, out_last} !== 34'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got v=%b pc=%h ir=%h last=%b, expected all zero",
                     out_valid, out_PC, out_IR, out_last);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        reset = 1'b0;
        tick(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_passthrough();
        bit ok;
        issue(16'h0010, 16'h0298, ok);
        checks++;
        if (!ok || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pass_accept: got in_ready=%b expected 1", in_ready);
        end
        tick(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        checks++;
        if ({out_valid, out_PC, out_IR, out_last} !== {1'b1, 16'h0010, 16'h0298, 1'b1}) begin
            errors++;
            $display("[TB] FAIL pass_output: got v=%b pc=%h ir=%h last=%b, expected v=1 pc=0010 ir=0298 last=1",
                     out_valid, out_PC, out_IR, out_last);
        end
    endtask

    task automatic test_lm_expand();
        bit          ok;
        logic [15:0] exp_ir [4] = '{16'h4040, 16'h4441, 16'h4A42, 16'h4E43};
        issue(16'h0100, 16'h62A5, ok);
        checks++;
        if (!ok || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lm_accept: got in_ready=%b expected 1", in_ready);
        end
        tick(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lm_bubble: got v=%b in_ready=%b expected 0 0", out_valid, in_ready);
        end
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
            checks++;
            if ({out_valid, out_PC, out_IR, out_last} !== {1'b1, 16'h0100, exp_ir[k], (k == 3)}) begin
                errors++;
                $display("[TB] FAIL lm_op%0d: got v=%b pc=%h ir=%h last=%b, expected v=1 pc=0100 ir=%h last=%b",
                         k, out_valid, out_PC, out_IR, out_last, exp_ir[k], (k == 3));
            end
            checks++;
            if (in_ready !== (k == 3)) begin
                errors++;
                $display("[TB] FAIL lm_stall%0d: got in_ready=%b expected %b", k, in_ready, (k == 3));
            end
        end
        tick(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lm_done: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_ra_last();
        bit ok, to;
        issue(16'h0200, 16'h6206, ok);
        collect(20, to);
        checks++;
        if (!ok || to || got.size() != 2 || got[0] !== {16'h0200, 16'h4441, 1'b0}
                || got[1] !== {16'h0200, 16'h4240, 1'b1}) begin
            errors++;
            $display("[TB] FAIL lm_ra_last: got n=%0d ir0=%h ir1=%h timeout=%b, expected n=2 ir0=4441 ir1=4240",
                     got.size(), got[0].ir, got[1].ir, to);
        end
        issue(16'h0210, 16'h7681, ok);
        collect(20, to);
        checks++;
        if (!ok || to || got.size() != 2 || got[0] !== {16'h0210, 16'h50C0, 1'b0}
                || got[1] !== {16'h0210, 16'h5EC1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL sm_expand: got n=%0d ir0=%h ir1=%h timeout=%b, expected n=2 ir0=50C0 ir1=5EC1",
                     got.size(), got[0].ir, got[1].ir, to);
        end
    endtask

    task automatic test_backpressure();
        bit          ok, ordy;
        int          h, stall;
        logic [15:0] exp_ir [4] = '{16'h4040, 16'h4441, 16'h4A42, 16'h4E43};
        issue(16'h0300, 16'h62A5, ok);
        got.delete();
        h = 0;
        stall = 0;
        for (int i = 0; i < 40; i++) begin
            ordy = !(h == 1 && stall < 3);
            tick(1'b0, 16'h0, 16'h0, ordy, 1'b0);
            if (out_valid === 1'b1) begin
                if (!ordy) begin
                    stall++;
                    checks++;
                    if (out_IR !== 16'h4441 || out_PC !== 16'h0300) begin
                        errors++;
                        $display("[TB] FAIL bp_hold%0d: got ir=%h pc=%h expected ir=4441 pc=0300",
                                 stall, out_IR, out_PC);
                    end
                end else begin
                    got.push_back(op_t'({out_PC, out_IR, out_last}));
                    h++;
                    if (out_last) break;
                end
            end
        end
        checks++;
        if (!ok || got.size() != 4 || stall != 3) begin
            errors++;
            $display("[TB] FAIL bp_count: got ops=%0d stalls=%0d expected ops=4 stalls=3", got.size(), stall);
        end
        foreach (got[k]) begin
            checks++;
            if (k < 4 && got[k].ir !== exp_ir[k]) begin
                errors++;
                $display("[TB] FAIL bp_op%0d: got ir=%h expected %h", k, got[k].ir, exp_ir[k]);
            end
        end
    endtask

    task automatic test_flush();
        bit ok;
        int h;
        issue(16'h0400, 16'h62A5, ok);
        h = 0;
        for (int i = 0; i < 20 && h < 2; i++) begin
            tick(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
            if (out_valid === 1'b1) h++;
        end
        checks++;
        if (!ok || h != 2) begin
            errors++;
            $display("[TB] FAIL flush_setup: got handshakes=%0d expected 2", h);
        end
        tick(1'b1, 16'h0410, 16'h0298, 1'b1, 1'b1);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_blocks_accept: got in_ready=%b expected 0", in_ready);
        end
        tick(1'b1, 16'h0410, 16'h0298, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_kill: got v=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        tick(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        checks++;
        if ({out_valid, out_PC, out_IR, out_last} !== {1'b1, 16'h0410, 16'h0298, 1'b1}) begin
            errors++;
            $display("[TB] FAIL flush_next_instr: got v=%b pc=%h ir=%h last=%b, expected v=1 pc=0410 ir=0298 last=1",
                     out_valid, out_PC, out_IR, out_last);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL flush_no_residue%0d: got out_valid=%b ir=%h expected 0", i, out_valid, out_IR);
            end
        end
    endtask

    task automatic test_empty_and_reset();
        bit ok;
        issue(16'h0500, 16'h6500, ok);
        tick(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        checks++;
        if (!ok || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL empty_list: got v=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        issue(16'h0600, 16'h62A5, ok);
        tick(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        tick(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_IR !== 16'h4040) begin
            errors++;
            $display("[TB] FAIL mid_seq_op: got v=%b ir=%h expected 1 4040", out_valid, out_IR);
        end
        reset = 1'b1;
        tick(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_in_ready_mid: got %b expected 0", in_ready);
        end
        reset = 1'b0;
        tick(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        checks++;
        if ({out_valid, out_PC, out_IR, out_last} !== 34'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid_seq: got v=%b pc=%h ir=%h last=%b rdy=%b, expected zeros rdy=1",
                     out_valid, out_PC, out_IR, out_last, in_ready);
        end
        tick(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_no_residue: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_random();
        bit          v, ordy, fl;
        logic [15:0] ir, pc;
        int          sel;
        reset = 1'b1;
        tick(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            v    = ($urandom_range(0, 9) < 7);
            ir   = 16'($urandom);
            pc   = 16'($urandom);
            sel  = $urandom_range(0, 9);
            if (sel < 2)      ir[15:12] = 4'b0110;
            else if (sel < 4) ir[15:12] = 4'b0111;
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 39) == 0);
            tick(v, pc, ir, ordy, fl);
            checks++;
            if (in_ready !== exp_in_ready) begin
                errors++;
                $display("[TB] FAIL rnd_in_ready cyc%0d: got %b expected %b", c, in_ready, exp_in_ready);
            end
            checks++;
            if (out_valid !== exp_out_valid) begin
                errors++;
                $display("[TB] FAIL rnd_out_valid cyc%0d: got %b expected %b", c, out_valid, exp_out_valid);
            end
            if (exp_out_valid) begin
                checks++;
                if ({out_PC, out_IR, out_last} !== exp_head) begin
                    errors++;
                    $display("[TB] FAIL rnd_op cyc%0d: got pc=%h ir=%h last=%b expected pc=%h ir=%h last=%b",
                             c, out_PC, out_IR, out_last, exp_head.pc, exp_head.ir, exp_head.last);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_lm_expand();
        test_ra_last();
        test_backpressure();
        test_flush();
        test_empty_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
